// File: rtl/control.sv
// Main instruction decoder for the ARK processor: registered control outputs, sticky HALT.
// Optional build macro CONTROL_ILLEGAL_HALT_EN makes reserved opcodes 0xA-0xE halt like 0xF.
module control (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] OPCODE,
    output logic [1:0] ALU_OP,
    output logic [1:0] ALU_SRC_B,
    output logic       REG_WRITE,
    output logic       BRANCH,
    output logic       MEM_WRITE,
    output logic       MEM_READ,
    output logic       REG_DST,
    output logic       MEM_TO_REG,
    output logic       HALT
);

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;

    localparam logic [1:0] SRC_RT  = 2'd0;
    localparam logic [1:0] SRC_IMM = 2'd1;
    localparam logic [1:0] SRC_ONE = 2'd2;

    logic [1:0] alu_op_s;
    logic [1:0] alu_src_b_s;
    logic       reg_write_s;
    logic       branch_s;
    logic       mem_write_s;
    logic       mem_read_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       halt_s;

    // Next-state decode; once halted every datapath control is held at zero.
    always_comb begin
        alu_op_s     = ALU_ADD;
        alu_src_b_s  = SRC_RT;
        reg_write_s  = 1'b0;
        branch_s     = 1'b0;
        mem_write_s  = 1'b0;
        mem_read_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        halt_s       = 1'b0;
        if (HALT) begin
            halt_s = 1'b1;
        end else begin
            case (OPCODE)
                4'h0, 4'h1, 4'h2, 4'h3: begin
                    alu_op_s    = OPCODE[1:0];
                    reg_write_s = 1'b1;
                    reg_dst_s   = 1'b1;
                end
                4'h4: begin
                    alu_src_b_s = SRC_IMM;
                    reg_write_s = 1'b1;
                end
                4'h5: begin
                    alu_src_b_s  = SRC_IMM;
                    mem_read_s   = 1'b1;
                    mem_to_reg_s = 1'b1;
                    reg_write_s  = 1'b1;
                end
                4'h6: begin
                    alu_src_b_s = SRC_IMM;
                    mem_write_s = 1'b1;
                end
                4'h7: begin
                    alu_op_s = ALU_SUB;
                    branch_s = 1'b1;
                end
                4'h8: begin
                    alu_src_b_s = SRC_ONE;
                    reg_write_s = 1'b1;
                end
                4'h9: begin
                    alu_op_s    = ALU_SUB;
                    alu_src_b_s = SRC_ONE;
                    reg_write_s = 1'b1;
                end
                4'hF: begin
                    halt_s = 1'b1;
                end
`ifdef CONTROL_ILLEGAL_HALT_EN
                default: begin
                    halt_s = 1'b1;
                end
`else
                default: begin
                    halt_s = 1'b0;
                end
`endif
            endcase
        end
    end

    // Output registers; reset clears everything including a latched halt.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ALU_OP     <= ALU_ADD;
            ALU_SRC_B  <= SRC_RT;
            REG_WRITE  <= 1'b0;
            BRANCH     <= 1'b0;
            MEM_WRITE  <= 1'b0;
            MEM_READ   <= 1'b0;
            REG_DST    <= 1'b0;
            MEM_TO_REG <= 1'b0;
            HALT       <= 1'b0;
        end else begin
            ALU_OP     <= alu_op_s;
            ALU_SRC_B  <= alu_src_b_s;
            REG_WRITE  <= reg_write_s;
            BRANCH     <= branch_s;
            MEM_WRITE  <= mem_write_s;
            MEM_READ   <= mem_read_s;
            REG_DST    <= reg_dst_s;
            MEM_TO_REG <= mem_to_reg_s;
            HALT       <= halt_s;
        end
    end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: table of opcode/expected-output vectors plus
// hand-written reset, halt and reserved-opcode sequences.
module tb_control;

    logic       CLK;
    logic       RST_N;
    logic [3:0] OPCODE;
    logic [1:0] ALU_OP;
    logic [1:0] ALU_SRC_B;
    logic       REG_WRITE;
    logic       BRANCH;
    logic       MEM_WRITE;
    logic       MEM_READ;
    logic       REG_DST;
    logic       MEM_TO_REG;
    logic       HALT;

    int n_checks = 0;
    int n_fail   = 0;

    // {alu_op[1:0], alu_src_b[1:0], reg_write, branch, mem_write, mem_read, reg_dst, mem_to_reg, halt}
    typedef struct {
        logic [3:0]  op;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    localparam logic [10:0] ZERO_OUT = 11'b00_00_0_0_0_0_0_0_0;
    localparam logic [10:0] HALT_OUT = 11'b00_00_0_0_0_0_0_0_1;
    localparam logic [10:0] ADD_OUT  = 11'b00_00_1_0_0_0_1_0_0;

    control dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .OPCODE     (OPCODE),
        .ALU_OP     (ALU_OP),
        .ALU_SRC_B  (ALU_SRC_B),
        .REG_WRITE  (REG_WRITE),
        .BRANCH     (BRANCH),
        .MEM_WRITE  (MEM_WRITE),
        .MEM_READ   (MEM_READ),
        .REG_DST    (REG_DST),
        .MEM_TO_REG (MEM_TO_REG),
        .HALT       (HALT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [10:0] outs();
        return {ALU_OP, ALU_SRC_B, REG_WRITE, BRANCH, MEM_WRITE, MEM_READ,
                REG_DST, MEM_TO_REG, HALT};
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = outs();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive an opcode, let one rising edge sample it, then check just after the edge.
    task automatic step(input logic [3:0] op, input string name, input logic [10:0] exp);
        OPCODE = op;
        @(posedge CLK);
        #1;
        check(name, exp);
    endtask

    initial begin
        vecs.push_back('{4'h2, 11'b10_00_1_0_0_0_1_0_0, "and"});
        vecs.push_back('{4'h1, 11'b01_00_1_0_0_0_1_0_0, "sub"});
        vecs.push_back('{4'h3, 11'b11_00_1_0_0_0_1_0_0, "or"});
        vecs.push_back('{4'h0, 11'b00_00_1_0_0_0_1_0_0, "add"});
        vecs.push_back('{4'h4, 11'b00_01_1_0_0_0_0_0_0, "addi"});
        vecs.push_back('{4'h5, 11'b00_01_1_0_0_1_0_1_0, "lw"});
        vecs.push_back('{4'h6, 11'b00_01_0_0_1_0_0_0_0, "sw"});
        vecs.push_back('{4'h7, 11'b01_00_0_1_0_0_0_0_0, "beq"});
        vecs.push_back('{4'h8, 11'b00_10_1_0_0_0_0_0_0, "inc"});
        vecs.push_back('{4'h9, 11'b01_10_1_0_0_0_0_0_0, "dec"});
`ifndef CONTROL_ILLEGAL_HALT_EN
        vecs.push_back('{4'hA, ZERO_OUT, "rsv_a"});
        vecs.push_back('{4'hC, ZERO_OUT, "rsv_c"});
        vecs.push_back('{4'hE, ZERO_OUT, "rsv_e"});
`endif
        vecs.push_back('{4'h3, 11'b11_00_1_0_0_0_1_0_0, "or_again"});

        // Reset held with a live opcode: outputs must stay zero across edges.
        RST_N  = 1'b0;
        OPCODE = 4'h2;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_hold", ZERO_OUT);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("reset_release_no_edge", ZERO_OUT);
        step(4'h2, "first_decode_and", 11'b10_00_1_0_0_0_1_0_0);

        foreach (vecs[i]) step(vecs[i].op, vecs[i].name, vecs[i].exp);

        // Opcode changes between edges must not disturb the registered outputs.
        step(4'h4, "addi_before_glitch", 11'b00_01_1_0_0_0_0_0_0);
        OPCODE = 4'h7;
        #3;
        check("opcode_change_no_edge", 11'b00_01_1_0_0_0_0_0_0);

        // Sticky halt.
        step(4'hF, "halt_set", HALT_OUT);
        for (int k = 0; k < 5; k++) step(4'h0, "halt_sticky", HALT_OUT);
        step(4'h5, "halt_ignores_lw", HALT_OUT);

        // Asynchronous reset mid-cycle clears the latched halt immediately.
        OPCODE = 4'h0;
        #2;
        RST_N = 1'b0;
        #1;
        check("async_reset_clears_halt", ZERO_OUT);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("decode_after_reset", ADD_OUT);

        // Reserved opcode behaviour depends on the build option.
`ifdef CONTROL_ILLEGAL_HALT_EN
        step(4'hB, "rsv_b_halts", HALT_OUT);
        step(4'h0, "rsv_b_halt_sticky", HALT_OUT);
`else
        step(4'hB, "rsv_b_nop", ZERO_OUT);
        step(4'h0, "rsv_b_no_halt", ADD_OUT);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control.md
# control

Main instruction decoder of the single-issue ARK processor. Decodes the 4-bit opcode into the ALU, register-file, memory, branch and halt control signals that steer the datapath. Outputs are registered, giving one cycle of latency. HALT is sticky until reset.

## Interface
- No parameters.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- OPCODE  in  4  instruction opcode from the fetch stage.
- ALU_OP  out  2  ALU operation, cast to `definitions::op_mne`: 0 ADD, 1 SUB, 2 AND, 3 OR.
- ALU_SRC_B  out  2  ALU B-operand select: 0 register rt, 1 sign-extended immediate, 2 constant +1, 3 reserved (never driven).
- REG_WRITE  out  1  register-file write enable.
- BRANCH  out  1  conditional branch; the PC logic qualifies it with ALU zero.
- MEM_WRITE  out  1  data-memory write enable.
- MEM_READ  out  1  data-memory read enable.
- REG_DST  out  1  destination register select: 1 rd (R-type), 0 rt (I-type).
- MEM_TO_REG  out  1  write-back source: 1 memory, 0 ALU.
- HALT  out  1  processor halted; sticky.

## Operation
Decode map. Any flag not listed is 0.
- 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR:
  - ALU_OP = OPCODE[1:0], ALU_SRC_B = 0.
  - REG_WRITE = 1, REG_DST = 1.
- 0x4 ADDI: ALU_OP = ADD, ALU_SRC_B = 1, REG_WRITE = 1.
- 0x5 LW: ALU_OP = ADD, ALU_SRC_B = 1, MEM_READ = 1, MEM_TO_REG = 1, REG_WRITE = 1.
- 0x6 SW: ALU_OP = ADD, ALU_SRC_B = 1, MEM_WRITE = 1.
- 0x7 BEQ: ALU_OP = SUB, ALU_SRC_B = 0, BRANCH = 1.
- 0x8 INC: ALU_OP = ADD, ALU_SRC_B = 2, REG_WRITE = 1.
- 0x9 DEC: ALU_OP = SUB, ALU_SRC_B = 2, REG_WRITE = 1.
- 0xA–0xE reserved: decode as NOP (all outputs 0, ALU_OP = ADD).
- 0xF HALT: HALT = 1, all other outputs 0.

Halt behaviour:
- Once HALT is 1 it stays 1 until RST_N is asserted, whatever OPCODE does afterwards.
- While halted, REG_WRITE, MEM_WRITE, MEM_READ, BRANCH, MEM_TO_REG, REG_DST, ALU_SRC_B and ALU_OP are forced to 0. No side effects occur after a halt.

Invariants:
- MEM_READ and MEM_WRITE are never 1 together.
- MEM_TO_REG = 1 implies MEM_READ = 1.
- ALU_SRC_B never equals 3.

## Timing
- OPCODE is sampled on the rising CLK edge. The decoded outputs are valid from that edge until the next one (latency 1 cycle, throughput 1 per cycle).
- Reset values while RST_N = 0 (applied asynchronously): every output is 0, i.e. ALU_OP = ADD, ALU_SRC_B = 0, all flags 0, HALT = 0.
- The first decode happens on the first rising edge after RST_N deasserts.
- Reset asserted mid-operation clears all outputs immediately, including a latched HALT, without waiting for a clock edge.
- Opcode 0xF is sampled on edge N: HALT = 1 from edge N onward. Opcodes sampled on later edges are ignored.
- OPCODE changes between edges have no effect on the outputs.

## Configuration
- Macro `CONTROL_ILLEGAL_HALT_EN`.
- Defined: reserved opcodes 0xA–0xE decode as HALT. HALT latches and all other outputs go to 0, identical to 0xF.
- Undefined (default): reserved opcodes decode as NOP and HALT is unaffected.

## Test plan
- Reset: hold RST_N = 0 with OPCODE = 0x2 and toggle CLK → all outputs stay 0. Release RST_N; the next edge gives ALU_OP = 2 (AND), REG_WRITE = 1, REG_DST = 1, ALU_SRC_B = 0.
- Sequence OPCODE = 2, 1, 3 on consecutive edges → ALU_OP = AND, SUB, OR, each one cycle after it is applied. REG_WRITE = 1 and REG_DST = 1 throughout.
- OPCODE = 0x5 → MEM_READ = 1, MEM_TO_REG = 1, REG_WRITE = 1, ALU_SRC_B = 1, REG_DST = 0. Then OPCODE = 0x6 → MEM_WRITE = 1, MEM_READ = 0, REG_WRITE = 0.
- OPCODE = 0x7 → BRANCH = 1, ALU_OP = SUB, REG_WRITE = 0. OPCODE = 0x8 → ALU_SRC_B = 2, ALU_OP = ADD, REG_WRITE = 1.
- OPCODE = 0xF, then 0x0 for 5 cycles → HALT stays 1 with all other outputs 0. Pulse RST_N low mid-cycle → HALT clears immediately; the next edge decodes ADD.
- OPCODE = 0xB → all outputs 0 when `CONTROL_ILLEGAL_HALT_EN` is undefined. With it defined, HALT = 1 and stays latched.
